// File: rtl/gx_write_gather_fifo_pkg.sv
// Shared definitions for the write-gather FIFO: store size encodings and word width.
package gx_pkg;

    localparam int GX_WORD_W = 32;

    localparam logic [1:0] GX_SZ_BYTE = 2'd0;
    localparam logic [1:0] GX_SZ_HALF = 2'd1;
    localparam logic [1:0] GX_SZ_WORD = 2'd2;
    localparam logic [1:0] GX_SZ_RSVD = 2'd3;

    // Bytes carried by a store of the given size; 0 for the reserved encoding.
    function automatic logic [2:0] gx_sz_bytes(input logic [1:0] sz);
        case (sz)
            GX_SZ_BYTE: gx_sz_bytes = 3'd1;
            GX_SZ_HALF: gx_sz_bytes = 3'd2;
            GX_SZ_WORD: gx_sz_bytes = 3'd4;
            default:    gx_sz_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/gx_write_gather_fifo_if.sv
// Store-side and CP-side handshake bundle of the write-gather FIFO.
interface gx_write_gather_fifo_if;
    import gx_pkg::*;

    logic                 wr_en;
    logic [1:0]           wr_size;
    logic [GX_WORD_W-1:0] wr_data;
    logic                 wr_ready;
    logic                 GXFIFORead;
    logic                 GXFIFOValid;
    logic [GX_WORD_W-1:0] GXFIFOData;

    // Producer of stores and consumer of FIFO words (CPU / CP side)
    modport master (
        output wr_en, wr_size, wr_data, GXFIFORead,
        input  wr_ready, GXFIFOValid, GXFIFOData
    );

    // The gather FIFO itself
    modport slave (
        input  wr_en, wr_size, wr_data, GXFIFORead,
        output wr_ready, GXFIFOValid, GXFIFOData
    );

endinterface

// File: rtl/gx_write_gather_fifo_ram.sv
// DEPTH x 32 simple dual-port storage: one write port, one registered read port.
module gx_fifo_ram
    import gx_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [GX_WORD_W-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [GX_WORD_W-1:0] rdata
);

    logic [GX_WORD_W-1:0] mem [DEPTH];

    // Write port plus registered read (read-before-write on address collision)
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/gx_write_gather_fifo.sv
// Gathers 1/2/4-byte big-endian CPU stores into 32-bit words and queues them
// first-word-fall-through for the command processor, with level flags.
module gx_write_gather_fifo
    import gx_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int HI_WM = 48,
    parameter int LO_WM = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    gx_write_gather_fifo_if.slave   bus,
    input  logic                    flush,
    output logic [AW:0]             count,
    output logic                    hi_wm,
    output logic                    lo_wm,
    output logic                    overflow
);

    logic [63:0]          gbuf;
    logic [1:0]           gcnt;
    logic [AW-1:0]        wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [GX_WORD_W-1:0] ram_q, byp_d;
    logic                 byp_q;

    logic [2:0]           nbytes, total;
    logic [31:0]          aligned;
    logic [63:0]          merged;
    logic                 accept, push, pop, post_empty;
    logic [AW:0]          count_nxt;

    assign bus.wr_ready    = (count <= (AW+1)'(DEPTH-1));
    assign bus.GXFIFOValid = (count != '0);
    // Head word comes from the bypass register when it was written into an empty FIFO
    assign bus.GXFIFOData  = byp_q ? byp_d : ram_q;

    // Gather packer: left-align the store, drop it in after the pending bytes
    always_comb begin
        nbytes = gx_sz_bytes(bus.wr_size);
        case (bus.wr_size)
            GX_SZ_BYTE: aligned = {bus.wr_data[7:0], 24'h0};
            GX_SZ_HALF: aligned = {bus.wr_data[15:0], 16'h0};
            default:    aligned = bus.wr_data;
        endcase
        merged     = gbuf | ({aligned, 32'h0} >> {gcnt, 3'b000});
        total      = {1'b0, gcnt} + nbytes;
        accept     = bus.wr_en && bus.wr_ready && (nbytes != 3'd0) && !flush;
        push       = accept && (total >= 3'd4);
        pop        = bus.GXFIFORead && bus.GXFIFOValid && !flush;
        count_nxt  = count + (AW+1)'(push) - (AW+1)'(pop);
        post_empty = (count == (AW+1)'(pop));
        rd_ptr_nxt = rd_ptr + AW'(pop);
    end

    // Gather buffer and pending byte count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gbuf <= '0;
            gcnt <= '0;
        end else if (flush) begin
            gbuf <= '0;
            gcnt <= '0;
        end else if (accept) begin
            gbuf <= push ? (merged << 32) : merged;
            gcnt <= push ? 2'(total - 3'd4) : 2'(total);
        end
    end

    // Pointers, count, watermarks and sticky overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hi_wm    <= 1'b0;
            lo_wm    <= 1'b1;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hi_wm    <= 1'b0;
            lo_wm    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            hi_wm    <= (count_nxt >= (AW+1)'(HI_WM));
            lo_wm    <= (count_nxt <= (AW+1)'(LO_WM));
            if (bus.wr_en && !bus.wr_ready) overflow <= 1'b1;
        end
    end

    // Bypass: a word landing in a FIFO that is empty after this cycle's pop
    // would miss the RAM's registered read, so capture it directly (zero when idle)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byp_q <= 1'b1;
            byp_d <= '0;
        end else if (flush) begin
            byp_q <= 1'b1;
            byp_d <= '0;
        end else begin
            byp_q <= post_empty;
            byp_d <= (post_empty && push) ? merged[63:32] : '0;
        end
    end

    gx_fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (merged[63:32]),
        .raddr (rd_ptr_nxt),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_gx_write_gather_fifo.sv
// Randomized and directed bench for the write-gather FIFO against a byte/word queue model.
module tb_gx_write_gather_fifo;
    import gx_pkg::*;

    localparam int DEPTH = 64;
    localparam int HI_WM = 48;
    localparam int LO_WM = 16;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [AW:0] count;
    logic        hi_wm, lo_wm, overflow;

    gx_write_gather_fifo_if bus();

    gx_write_gather_fifo #(.DEPTH(DEPTH), .HI_WM(HI_WM), .LO_WM(LO_WM)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .flush    (flush),
        .count    (count),
        .hi_wm    (hi_wm),
        .lo_wm    (lo_wm),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: pending gather bytes, stored words, sticky overflow
    logic [7:0]  m_bytes[$];
    logic [31:0] m_words[$];
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int m_size();
        return m_words.size();
    endfunction

    task automatic m_clear(input bit keep_ovf);
        m_bytes.delete();
        m_words.delete();
        if (!keep_ovf) m_ovf = 0;
    endtask

    // One clock edge of the reference model, evaluated with pre-edge state
    task automatic m_edge(input bit en, input logic [1:0] sz, input logic [31:0] d,
                          input bit rd, input bit fl);
        int  n;
        bit  ready;
        if (fl) begin
            m_clear(0);
            return;
        end
        ready = (m_size() < DEPTH);
        if (en && !ready) m_ovf = 1;
        if (rd && m_size() > 0) void'(m_words.pop_front());
        if (en && ready && sz != 2'd3) begin
            n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            for (int i = n - 1; i >= 0; i--) m_bytes.push_back(d[8*i +: 8]);
            if (m_bytes.size() >= 4) begin
                logic [31:0] w;
                w = '0;
                for (int k = 0; k < 4; k++) w = {w[23:0], m_bytes.pop_front()};
                m_words.push_back(w);
            end
        end
    endtask

    task automatic chk_all();
        int s;
        s = m_size();
        chk("count",    32'(count),           32'(s));
        chk("valid",    32'(bus.GXFIFOValid), 32'(s > 0));
        if (s > 0) chk("data", bus.GXFIFOData, m_words[0]);
        chk("wr_ready", 32'(bus.wr_ready),    32'(s < DEPTH));
        chk("hi_wm",    32'(hi_wm),           32'(s >= HI_WM));
        chk("lo_wm",    32'(lo_wm),           32'(s <= LO_WM));
        chk("overflow", 32'(overflow),        32'(m_ovf));
    endtask

    // Drive one cycle from a negedge, advance model at posedge, check at next negedge
    task automatic cyc(input bit en, input logic [1:0] sz, input logic [31:0] d,
                       input bit rd, input bit fl);
        bus.wr_en = en; bus.wr_size = sz; bus.wr_data = d;
        bus.GXFIFORead = rd; flush = fl;
        @(posedge clk);
        m_edge(en, sz, d, rd, fl);
        @(negedge clk);
        chk_all();
    endtask

    task automatic idle();
        cyc(0, 2'd0, 32'h0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && m_size() > 0; i++) cyc(0, 2'd0, 32'h0, 1, 0);
        chk("drained", 32'(count), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"},    32'(count),           32'd0);
        chk({tag, "_valid"},    32'(bus.GXFIFOValid), 32'd0);
        chk({tag, "_data"},     bus.GXFIFOData,       32'd0);
        chk({tag, "_wr_ready"}, 32'(bus.wr_ready),    32'd1);
        chk({tag, "_hi"},       32'(hi_wm),           32'd0);
        chk({tag, "_lo"},       32'(lo_wm),           32'd1);
        chk({tag, "_ovf"},      32'(overflow),        32'd0);
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_size = 2'd0; bus.wr_data = '0; bus.GXFIFORead = 0;
        m_ovf = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        resetn = 1'b1;
        @(negedge clk);
        chk_all();

        // Four bytes gather into one big-endian word, visible next cycle
        cyc(1, GX_SZ_BYTE, 32'h11, 0, 0);
        cyc(1, GX_SZ_BYTE, 32'h22, 0, 0);
        cyc(1, GX_SZ_BYTE, 32'h33, 0, 0);
        chk("bytes_not_yet", 32'(bus.GXFIFOValid), 32'd0);
        cyc(1, GX_SZ_BYTE, 32'h44, 0, 0);
        chk("bytes_word", bus.GXFIFOData, 32'h11223344);
        chk("bytes_count", 32'(count), 32'd1);
        drain();

        // Mixed sizes straddling a word boundary
        cyc(1, GX_SZ_BYTE, 32'hAA, 0, 0);
        cyc(1, GX_SZ_HALF, 32'hBBCC, 0, 0);
        cyc(1, GX_SZ_WORD, 32'hDDEEFF00, 0, 0);
        chk("mix_w0", bus.GXFIFOData, 32'hAABBCCDD);
        cyc(1, GX_SZ_RSVD, 32'h5555_5555, 0, 0);
        cyc(1, GX_SZ_BYTE, 32'h12, 1, 0);
        chk("mix_w1", bus.GXFIFOData, 32'hEEFF0012);
        drain();

        // Fill to DEPTH, overflow on an extra store, then drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1, GX_SZ_WORD, 32'hC000_0000 + 32'(i), 0, 0);
        chk("full_ready", 32'(bus.wr_ready), 32'd0);
        chk("full_hi", 32'(hi_wm), 32'd1);
        cyc(1, GX_SZ_WORD, 32'hDEAD_BEEF, 0, 0);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_count", 32'(count), 32'(DEPTH));
        cyc(1, GX_SZ_WORD, 32'hDEAD_BEEF, 1, 0);
        chk("full_pop_no_pass", 32'(count), 32'(DEPTH - 1));
        drain();
        chk("empty_lo", 32'(lo_wm), 32'd1);

        // Streaming at count=1 with read held high; pointers wrap many times
        cyc(1, GX_SZ_WORD, 32'hA000_0000, 0, 0);
        for (int i = 1; i < 3 * DEPTH; i++) cyc(1, GX_SZ_WORD, 32'hA000_0000 + 32'(i), 1, 0);
        chk("stream_count", 32'(count), 32'd1);
        drain();

        // Flush beats a same-cycle store and pop
        for (int i = 0; i < 10; i++) cyc(1, GX_SZ_WORD, $urandom, 0, 0);
        cyc(1, GX_SZ_HALF, 32'h0000_ABCD, 0, 0);
        cyc(1, GX_SZ_WORD, 32'h1234_5678, 1, 1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(bus.GXFIFOValid), 32'd0);
        chk("flush_ovf", 32'(overflow), 32'd0);
        cyc(1, GX_SZ_BYTE, 32'h01, 0, 0);
        cyc(1, GX_SZ_HALF, 32'h0203, 0, 0);
        cyc(1, GX_SZ_BYTE, 32'h04, 0, 0);
        chk("flush_gcnt0", bus.GXFIFOData, 32'h01020304);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) cyc(1, GX_SZ_WORD, $urandom, 0, 0);
        cyc(1, GX_SZ_BYTE, 32'h77, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd5);
        bus.wr_en = 0; bus.GXFIFORead = 0;
        #2 resetn = 1'b0;
        #1 check_reset_vals("arst");
        m_clear(0);
        @(negedge clk);
        resetn = 1'b1;
        idle();
        cyc(1, GX_SZ_WORD, 32'hFACE_B00C, 0, 0);
        chk("arst_resume", bus.GXFIFOData, 32'hFACE_B00C);

        // Random traffic: fill-biased then drain-biased, rare flushes
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1200; i++) begin
                cyc($urandom_range(0, 3) != 0, 2'($urandom), $urandom,
                    (ph == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8),
                    $urandom_range(0, 299) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
